// File: rtl/mux_sel_arbiter_if.sv
// Stream/select bundle between the mux_sel_arbiter and its requesters and consumer.
// The master side is the arbiter; the slave side is the requester/consumer environment.
interface mux_sel_arbiter_if #(
    parameter int S = 1
);
    localparam int NREQ = 1 << S;

    // Handshake: a beat moves on a cycle where o_valid and i_ready are both high;
    // o_valid never depends on i_ready, and i_ready may toggle freely.
    logic [NREQ-1:0] i_req;
    logic [NREQ-1:0] i_last;
    logic            i_ready;
    logic            o_valid;
    logic [S-1:0]    o_sel;
    logic [NREQ-1:0] o_gnt;
    logic            o_preempt;

    modport master (
        input  i_req, i_last, i_ready,
        output o_valid, o_sel, o_gnt, o_preempt
    );

    modport slave (
        output i_req, i_last, i_ready,
        input  o_valid, o_sel, o_gnt, o_preempt
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that owns the mux select for a whole burst, with an optional
// per-grant beat limit that force-releases long bursts.
module mux_sel_arbiter #(
    parameter int MUX_CONFIG = 1,
    parameter int S          = MUX_CONFIG,
    parameter int MAX_BEATS  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    mux_sel_arbiter_if.master  bus,
    output logic               o_dbg_state
);
    localparam int NREQ = 1 << S;
    localparam bit LIMIT_EN = (MAX_BEATS != 0);
    localparam logic [7:0] LIMIT_M1 = 8'(MAX_BEATS - 1);

    if (S != 1 && S != 2) begin : g_bad_s
        $fatal(1, "In %m S=%0d; must be 1 or 2", S);
    end
    if (MAX_BEATS < 0 || MAX_BEATS > 255) begin : g_bad_max
        $fatal(1, "In %m MAX_BEATS=%0d; must be 0..255", MAX_BEATS);
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [S-1:0]    r_sel;
    logic [S-1:0]    r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [7:0]      r_beat_cnt;
    logic            r_preempt;

    logic [S-1:0]    w_idx;
    logic [S-1:0]    w_pick;
    logic            w_found;
    logic            w_cur_req;
    logic            w_cur_last;
    logic            w_valid;
    logic            w_accept;
    logic            w_force;
    logic            w_release;

    assign w_cur_req  = bus.i_req[r_sel];
    assign w_cur_last = bus.i_last[r_sel];
    assign w_valid    = (r_state == ST_BUSY) && w_cur_req;
    assign w_accept   = w_valid && bus.i_ready;
    // A last beat landing exactly on the limit is a normal end, not a preemption.
    assign w_force    = LIMIT_EN && w_accept && !w_cur_last && (r_beat_cnt == LIMIT_M1);
    assign w_release  = (r_state == ST_BUSY) &&
                        (!w_cur_req || (w_accept && (w_cur_last || w_force)));

    // First requester at or after r_ptr, wrapping through NREQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = r_ptr + S'(i);
            if (!w_found && bus.i_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found)   w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_release) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt      <= '0;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
            r_preempt  <= 1'b0;
        end else begin
            r_preempt <= w_force;
            if (r_state == ST_IDLE && w_found) begin
                r_gnt      <= NREQ'(1) << w_pick;
                r_sel      <= w_pick;
                r_beat_cnt <= '0;
            end else if (r_state == ST_BUSY) begin
                if (w_accept && r_beat_cnt != 8'hFF) begin
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                end
                // r_sel is left alone so the mux input stays put through the bubble.
                if (w_release) begin
                    r_gnt <= '0;
                    r_ptr <= r_sel + S'(1);
                end
            end
        end
    end

    always_comb begin
        bus.o_valid   = w_valid;
        bus.o_sel     = r_sel;
        bus.o_gnt     = r_gnt;
        bus.o_preempt = r_preempt;
        o_dbg_state   = (r_state == ST_BUSY);
    end
endmodule
